// File: rtl/enc_bundler_acc.sv
`default_nettype none
// ============================================================================
// Module  : enc_bundler_acc
// Brief   : Bundles NUM_PACKS binder packs into one thresholded query HV.
// Revision: 1.0 - initial release
// ============================================================================
module enc_bundler_acc #(
    parameter int HV_DIM    = 1024,
    parameter int NUM_IN    = 59,
    parameter int NUM_PACKS = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_encoding,
    input  logic              in_valid,
    input  logic [HV_DIM-1:0] shifted_hv [0:NUM_IN-1],
    input  logic [CNT_W-1:0]  threshold,
    output logic [HV_DIM-1:0] query_hv,
    output logic              query_valid,
    output logic              busy
);

    localparam int c_pop_w  = $clog2(NUM_IN + 1);
    localparam int c_sum_w  = ((CNT_W > c_pop_w) ? CNT_W : c_pop_w) + 1;
    localparam int c_pack_w = (NUM_PACKS > 1) ? $clog2(NUM_PACKS) : 1;
    localparam logic [c_pack_w-1:0] c_last_pack = c_pack_w'(NUM_PACKS - 1);
    localparam logic [c_sum_w-1:0]  c_cnt_max   = {{(c_sum_w-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_pack_w-1:0] r_pack_cnt;
    logic [CNT_W-1:0]    r_threshold;
    logic                r_s1_valid;
    logic                w_accept;
    logic                w_last;
    logic                w_emit;
    logic [HV_DIM-1:0]   w_hit;

    // start_encoding takes priority over a coincident pack
    assign w_accept = (r_state == ACCUM) && in_valid && !start_encoding;
    assign w_last   = w_accept && (r_pack_cnt == c_last_pack);
    assign w_emit   = (r_state == OUT) && !start_encoding;
    assign busy     = (r_state != IDLE);

    always_comb begin
        w_state_next = r_state;
        if (start_encoding) begin
            w_state_next = ACCUM;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                ACCUM:   w_state_next = w_last ? FLUSH : ACCUM;
                FLUSH:   w_state_next = OUT;
                OUT:     w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_pack_cnt  <= '0;
            r_threshold <= '0;
            r_s1_valid  <= 1'b0;
            query_hv    <= '0;
            query_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_s1_valid  <= w_accept;
            query_valid <= w_emit;
            if (start_encoding) begin
                r_pack_cnt  <= '0;
                r_threshold <= threshold;
            end else if (w_accept) begin
                r_pack_cnt  <= w_last ? '0 : r_pack_cnt + 1'b1;
            end
            if (w_emit) begin
                query_hv <= w_hit;
            end
        end
    end

    // Per-dimension popcount stage, saturating accumulator and threshold compare
    for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
        logic [c_pop_w-1:0] w_pop;
        logic [c_pop_w-1:0] r_pop;
        logic [CNT_W-1:0]   r_cnt;
        logic [c_sum_w-1:0] w_sum;

        always_comb begin
            w_pop = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                w_pop = w_pop + c_pop_w'(shifted_hv[i][d]);
            end
        end

        assign w_sum    = c_sum_w'(r_cnt) + c_sum_w'(r_pop);
        assign w_hit[d] = (r_cnt >= r_threshold);

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                r_pop <= '0;
                r_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_pop <= w_pop;
                end
                if (start_encoding) begin
                    r_cnt <= '0;
                end else if (r_s1_valid) begin
                    r_cnt <= (w_sum > c_cnt_max) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enc_bundler_acc.sv
`default_nettype none
// ============================================================================
// Module  : tb_enc_bundler_acc
// Brief   : Directed self-checking bench for enc_bundler_acc.
// Revision: 1.0 - initial release
// ============================================================================
module tb_enc_bundler_acc;

    localparam int HV_DIM = 1024;
    localparam int NUM_IN = 59;
    localparam int S_DIM  = 16;

    logic              clk = 1'b0;
    logic              nrst;
    logic              start_encoding;
    logic              in_valid;
    logic [HV_DIM-1:0] shv [0:NUM_IN-1];
    logic [7:0]        threshold;
    logic [HV_DIM-1:0] query_hv;
    logic              query_valid;
    logic              busy;

    logic [S_DIM-1:0]  shv_s [0:NUM_IN-1];
    logic [3:0]        threshold_s;
    logic [S_DIM-1:0]  query_hv_s;
    logic              query_valid_s;
    logic              busy_s;

    int checks = 0;
    int errors = 0;
    logic [HV_DIM-1:0] exp_hv;
    int seen;

    always #5 clk = ~clk;

    enc_bundler_acc u_dut (
        .clk            (clk),
        .nrst           (nrst),
        .start_encoding (start_encoding),
        .in_valid       (in_valid),
        .shifted_hv     (shv),
        .threshold      (threshold),
        .query_hv       (query_hv),
        .query_valid    (query_valid),
        .busy           (busy)
    );

    enc_bundler_acc #(.HV_DIM(S_DIM), .CNT_W(4)) u_sat (
        .clk            (clk),
        .nrst           (nrst),
        .start_encoding (start_encoding),
        .in_valid       (in_valid),
        .shifted_hv     (shv_s),
        .threshold      (threshold_s),
        .query_hv       (query_hv_s),
        .query_valid    (query_valid_s),
        .busy           (busy_s)
    );

    task automatic chk(input string tag, input logic [HV_DIM-1:0] obs, input logic [HV_DIM-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h (ones %0d) expected %0h (ones %0d)",
                     tag, obs[63:0], $countones(obs), exp[63:0], $countones(exp));
        end
    endtask

    task automatic set_hv(input logic ones);
        for (int i = 0; i < NUM_IN; i++) shv[i] = ones ? '1 : '0;
    endtask

    task automatic start(input logic [7:0] th, input logic iv);
        @(negedge clk);
        threshold      = th;
        start_encoding = 1'b1;
        in_valid       = iv;
        @(negedge clk);
        start_encoding = 1'b0;
        in_valid       = 1'b0;
    endtask

    task automatic pack(input int gap);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Called right after the last pack task returns (one cycle after acceptance)
    task automatic finish(input string tag, input logic [HV_DIM-1:0] exp);
        int n = 0;
        while (query_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, HV_DIM'(n), HV_DIM'(2));
        chk({tag, "_hv"}, query_hv, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, HV_DIM'(query_valid), '0);
        chk({tag, "_hold"}, query_hv, exp);
    endtask

    initial begin
        nrst           = 1'b0;
        start_encoding = 1'b0;
        in_valid       = 1'b0;
        threshold      = '0;
        threshold_s    = 4'd15;
        set_hv(1'b0);
        for (int i = 0; i < NUM_IN; i++) shv_s[i] = '1;
        #1;
        chk("rst_hv", query_hv, '0);
        chk("rst_qv", HV_DIM'(query_valid), '0);
        chk("rst_busy", HV_DIM'(busy), '0);
        @(negedge clk);
        nrst = 1'b1;

        // In_valid before any start is ignored
        pack(1);
        chk("idle_busy", HV_DIM'(busy), '0);

        // Basic encoding
        shv[0][5] = 1'b1;
        start(8'd2, 1'b0);
        chk("accum_busy", HV_DIM'(busy), HV_DIM'(1));
        repeat (4) pack(0);
        exp_hv = '0; exp_hv[5] = 1'b1;
        finish("basic", exp_hv);
        chk("basic_idle", HV_DIM'(busy), '0);

        // Threshold edges with all-ones input; saturating build checked alongside
        set_hv(1'b1);
        start(8'd237, 1'b0);
        repeat (4) pack(0);
        finish("th237", '0);
        start(8'd236, 1'b0);
        repeat (4) pack(0);
        finish("th236", '1);
        chk("sat_hv", HV_DIM'(query_hv_s), HV_DIM'(16'hFFFF));
        set_hv(1'b0);
        start(8'd0, 1'b0);
        chk("start_keeps_hv", query_hv, '1);
        repeat (4) pack(0);
        finish("th0", '1);

        // Gaps, plus in_valid held through FLUSH/OUT/IDLE
        set_hv(1'b0);
        shv[0][5] = 1'b1; shv[0][9] = 1'b1; shv[1][9] = 1'b1;
        start(8'd5, 1'b0);
        pack(3); pack(1); pack(2);
        @(negedge clk);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("gap_qv_early", HV_DIM'(query_valid), '0);
        @(negedge clk);
        exp_hv = '0; exp_hv[9] = 1'b1;
        chk("gap_qv", HV_DIM'(query_valid), HV_DIM'(1));
        chk("gap_hv", query_hv, exp_hv);
        @(negedge clk);
        in_valid = 1'b0;
        chk("gap_busy", HV_DIM'(busy), '0);

        // Restart after 2 packs
        set_hv(1'b0); shv[0][1] = 1'b1;
        start(8'd1, 1'b0);
        repeat (2) pack(0);
        set_hv(1'b0); shv[0][2] = 1'b1;
        start(8'd1, 1'b0);
        repeat (4) pack(0);
        exp_hv = '0; exp_hv[2] = 1'b1;
        finish("restart", exp_hv);

        // start_encoding coincident with in_valid
        set_hv(1'b0); shv[0][4] = 1'b1;
        start(8'd1, 1'b1);
        set_hv(1'b0); shv[0][3] = 1'b1;
        repeat (3) pack(0);
        chk("coinc_busy", HV_DIM'(busy), HV_DIM'(1));
        pack(0);
        exp_hv = '0; exp_hv[3] = 1'b1;
        finish("coinc", exp_hv);

        // Reset mid-encoding
        set_hv(1'b0); shv[0][7] = 1'b1;
        start(8'd1, 1'b0);
        repeat (3) pack(0);
        #2 nrst = 1'b0;
        #1;
        chk("mrst_hv", query_hv, '0);
        chk("mrst_qv", HV_DIM'(query_valid), '0);
        chk("mrst_busy", HV_DIM'(busy), '0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        pack(0);
        repeat (8) begin
            @(negedge clk);
            if (query_valid) seen++;
        end
        chk("mrst_noqv", HV_DIM'(seen), '0);
        start(8'd4, 1'b0);
        repeat (4) pack(0);
        exp_hv = '0; exp_hv[7] = 1'b1;
        finish("mrst_new", exp_hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
